// File: rtl/instruction_fetcher_if.sv
// Bundle of the fetch-stage buses: icache request/response, branch predictor
// lookup, instruction-queue head toward issue, and the ROB redirect.
interface instruction_fetcher_if;
  logic        icache_req_valid;
  logic [31:0] icache_req_addr;
  logic        icache_resp_valid;
  logic [31:0] icache_resp_inst;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic        issue_ready;
  logic        iq_valid;
  logic [31:0] iq_inst;
  logic [31:0] iq_pc;
  logic        iq_pred_taken;
  logic        rob_flush;
  logic [31:0] rob_target_pc;

  modport master (
    output icache_req_valid, icache_req_addr, pred_pc,
           iq_valid, iq_inst, iq_pc, iq_pred_taken,
    input  icache_resp_valid, icache_resp_inst, pred_taken,
           issue_ready, rob_flush, rob_target_pc
  );

  modport slave (
    input  icache_req_valid, icache_req_addr, pred_pc,
           iq_valid, iq_inst, iq_pc, iq_pred_taken,
    output icache_resp_valid, icache_resp_inst, pred_taken,
           issue_ready, rob_flush, rob_target_pc
  );
endinterface

// File: rtl/instruction_fetcher.sv
// Fetch stage: owns the PC, keeps one icache request in flight, pre-decodes
// JAL/branches for the next PC and queues fetched words. Define IF_BYPASS_EN
// to let a response reach the issue port in the same cycle when the queue is empty.
module instruction_fetcher #(
  parameter int          IQ_DEPTH_LOG = 3,
  parameter logic [31:0] RESET_PC     = 32'h0000_0000
) (
  input logic                   clk,
  input logic                   rst,
  input logic                   rdy,
  instruction_fetcher_if.master fif
);

  localparam int IQ_DEPTH = 1 << IQ_DEPTH_LOG;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [31:0]             pc_q, pc_d;
  logic [IQ_DEPTH_LOG-1:0] head_q, head_d;
  logic [IQ_DEPTH_LOG-1:0] tail_q, tail_d;
  logic [IQ_DEPTH_LOG:0]   count_q, count_d;

  logic [31:0] inst_mem_q  [IQ_DEPTH];
  logic [31:0] pc_mem_q    [IQ_DEPTH];
  logic        taken_mem_q [IQ_DEPTH];

  logic        full_s, empty_s, req_s, resp_s, byp_s, byp_take_s, enq_s, deq_s;
  logic [32:0] pd_s;

  // Returns {predicted_taken, next_pc} for a fetched word at pc.
  function automatic logic [32:0] predecode(input logic [31:0] inst,
                                            input logic [31:0] pc,
                                            input logic        taken_in);
    logic [31:0] imm_jal;
    logic [31:0] imm_br;
    imm_jal = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    imm_br  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    case (inst[6:0])
      7'b1101111: predecode = {1'b1, pc + imm_jal};
      7'b1100011: begin
        if (taken_in) begin
          predecode = {1'b1, pc + imm_br};
        end else begin
          predecode = {1'b0, pc + 32'd4};
        end
      end
      default:    predecode = {1'b0, pc + 32'd4};
    endcase
  endfunction

  // Handshake qualifiers; requests are held off in reset so outputs stay low.
  always_comb begin
    full_s  = count_q[IQ_DEPTH_LOG];
    empty_s = (count_q == '0);
    req_s   = ~rst & rdy & (state_q == ST_IDLE) & ~full_s & ~fif.rob_flush;
    resp_s  = rdy & (state_q == ST_WAIT) & fif.icache_resp_valid & ~fif.rob_flush;
`ifdef IF_BYPASS_EN
    byp_s   = empty_s & (state_q == ST_WAIT) & fif.icache_resp_valid & ~fif.rob_flush;
`else
    byp_s   = 1'b0;
`endif
    byp_take_s = byp_s & fif.issue_ready & rdy;
    enq_s      = resp_s & ~byp_take_s;
    deq_s      = rdy & ~fif.rob_flush & ~empty_s & fif.issue_ready;
    pd_s       = predecode(fif.icache_resp_inst, pc_q, fif.pred_taken);
  end

  // Next-state for the FSM, PC and queue pointers.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (!rdy) begin
      state_d = state_q;
    end else if (fif.rob_flush) begin
      pc_d    = fif.rob_target_pc;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      case (state_q)
        ST_WAIT: state_d = fif.icache_resp_valid ? ST_IDLE : ST_DROP;
        ST_DROP: state_d = ST_DROP;
        default: state_d = ST_IDLE;
      endcase
    end else begin
      case (state_q)
        ST_IDLE: state_d = req_s ? ST_WAIT : ST_IDLE;
        ST_WAIT: begin
          if (fif.icache_resp_valid) begin
            pc_d    = pd_s[31:0];
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WAIT;
          end
        end
        ST_DROP: state_d = fif.icache_resp_valid ? ST_IDLE : ST_DROP;
        default: state_d = ST_IDLE;
      endcase
      if (enq_s) begin
        tail_d = tail_q + IQ_DEPTH_LOG'(1);
      end else begin
        tail_d = tail_q;
      end
      if (deq_s) begin
        head_d = head_q + IQ_DEPTH_LOG'(1);
      end else begin
        head_d = head_q;
      end
      case ({enq_s, deq_s})
        2'b10:   count_d = count_q + (IQ_DEPTH_LOG+1)'(1);
        2'b01:   count_d = count_q - (IQ_DEPTH_LOG+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Queue storage; validity is tracked by the pointers, so no reset needed.
  always_ff @(posedge clk) begin
    if (enq_s) begin
      inst_mem_q[tail_q]  <= fif.icache_resp_inst;
      pc_mem_q[tail_q]    <= pc_q;
      taken_mem_q[tail_q] <= pd_s[32];
    end
  end

  // Head-of-queue view, zeroed when nothing is valid.
  always_comb begin
    fif.icache_req_valid = req_s;
    fif.icache_req_addr  = pc_q;
    fif.pred_pc          = pc_q;
    fif.iq_valid         = ~empty_s | byp_s;
    if (!empty_s) begin
      fif.iq_inst       = inst_mem_q[head_q];
      fif.iq_pc         = pc_mem_q[head_q];
      fif.iq_pred_taken = taken_mem_q[head_q];
    end else if (byp_s) begin
      fif.iq_inst       = fif.icache_resp_inst;
      fif.iq_pc         = pc_q;
      fif.iq_pred_taken = pd_s[32];
    end else begin
      fif.iq_inst       = 32'h0000_0000;
      fif.iq_pc         = 32'h0000_0000;
      fif.iq_pred_taken = 1'b0;
    end
  end

endmodule

// File: doc/instruction_fetcher.md
Name: instruction_fetcher

Overview:
- Front-end fetch stage that owns the PC and issues one-outstanding requests to the instruction cache.
- Pre-decodes each returned word for JAL and conditional branches, and picks the next PC using the branch predictor's combinational taken bit, which is indexed by the PC this block drives.
- Buffers fetched instructions, with their PC and predicted direction, in a FIFO drained by the decoder/issue stage.
- Redirects on ROB flush.

Parameters:
- IQ_DEPTH_LOG, 3, log2 of instruction-queue entries (default 8).
- RESET_PC, 32'h0, PC loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rdy  in  1  global enable; when low, all state holds. Reset still acts.
- icache_req_valid  out  1  fetch request strobe.
- icache_req_addr  out  32  fetch address; equals current pc.
- icache_resp_valid  in  1  one-cycle pulse; instruction word valid.
- icache_resp_inst  in  32  returned instruction word.
- pred_pc  out  32  PC presented to the predictor; equals current pc.
- pred_taken  in  1  predictor's taken bit for pred_pc (combinational).
- issue_ready  in  1  downstream accepts the head entry this cycle.
- iq_valid  out  1  head entry valid.
- iq_inst  out  32  head instruction.
- iq_pc  out  32  head PC.
- iq_pred_taken  out  1  head predicted-taken flag.
- rob_flush  in  1  mispredict redirect.
- rob_target_pc  in  32  correct PC on flush.

Behaviour:
- Reset (async):
  - pc=RESET_PC, state=IDLE, discard=0, head=tail=count=0.
  - All outputs low except icache_req_addr=pred_pc=RESET_PC.
- Registered state:
  - pc.
  - FSM state: IDLE, WAIT, DROP.
  - Circular queue of 2^IQ_DEPTH_LOG entries {inst, pc, taken}.
  - head, tail (IQ_DEPTH_LOG bits, natural wrap); count (IQ_DEPTH_LOG+1 bits).
- rdy=0: no state changes. Outputs still reflect held state. icache_req_valid forced 0.
- icache_req_valid = rdy & state==IDLE & count<2^IQ_DEPTH_LOG & ~rob_flush (combinational). On that edge, state goes to WAIT.
- Only one request is ever outstanding. Request gating on count<full guarantees the response never finds the queue full.
- WAIT, on icache_resp_valid & ~rob_flush:
  - Enqueue at tail.
  - Compute next pc and return to IDLE. The new PC is visible the next cycle, so minimum fetch period is 2 cycles.
- Next-PC pre-decode (opcode = inst[6:0]):
  - 1101111 (JAL): pc += sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}); taken=1.
  - 1100011 (branch): if pred_taken, pc += sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}), else pc+=4; taken=pred_taken.
  - Otherwise (including JALR): pc+=4, taken=0.
  - All adds are 32-bit modulo.
- Dequeue: iq_valid = count!=0; iq_* = entry[head]. Pop on edge when iq_valid & issue_ready & rdy.
- Count update:
  - Enqueue only: +1. Dequeue only: -1. Both: unchanged. Full with simultaneous deq is legal.
- rob_flush (priority over all else, while rdy):
  - head=tail=count=0; pc=rob_target_pc; no enqueue or dequeue that cycle.
  - Flush in IDLE, or in WAIT with resp_valid the same cycle: the response is dropped and state goes to IDLE.
  - Flush in WAIT without a response: state goes to DROP. In DROP, the next icache_resp_valid is discarded and state goes to IDLE.
  - Flush in DROP: pc is updated and state stays DROP.
  - No request is issued in DROP.

Optional Feature:
- Macro IF_BYPASS_EN.
- Defined: when count==0, state==WAIT, icache_resp_valid, ~rob_flush:
  - iq_valid=1 and iq_inst/iq_pc/iq_pred_taken come combinationally from the response.
  - If issue_ready is also high, the entry is consumed directly and not enqueued.
  - Next-PC logic is unchanged.
- Undefined: a fetched instruction appears on iq_* no earlier than the cycle after its response.

Test Plan:
- Reset with RESET_PC=0; icache returns 32'h00000013 (addi) 1 cycle after each request; issue_ready=1 -> icache_req_addr sequence 0,4,8,C. iq_pc sequence the same, with iq_pred_taken=0.
- At pc=0x10, return JAL 32'h0100006F (offset +16) -> next request at 0x20; queued entry has pc=0x10, taken=1.
- At pc=0x40, return BEQ with offset -8 (32'hFE000CE3):
  - With pred_taken=1 -> next request 0x38, taken=1.
  - Repeat with pred_taken=0 -> next request 0x44, taken=0.
- issue_ready=0 with continuous responses -> exactly 8 entries enqueued. icache_req_valid stays 0 while count==8. One pop re-enables a request the next cycle.
- Flush in WAIT before the response, rob_target_pc=0x100 -> late response discarded, queue empty, next request to 0x100. Also check flush coincident with a response: response dropped.
- Assert rst asynchronously mid-WAIT with 3 queued entries -> iq_valid=0 immediately, next request to RESET_PC after release.
